wb_port_arbiter: RTL
====================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4, giving the consecutive cycles an aux entry may wait before a forced pipeline stall (legal 1..15).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 RegWrite_in  input  1  pipeline WB write request for this cycle.
REQ-005 RegWriteDst_in  input  5  pipeline WB destination register.
REQ-006 WB_Data_in  input  32  pipeline WB write data.
REQ-007 Aux_valid  input  1  multi-cycle unit (MDU / late load) offers a write.
REQ-008 Aux_Dst  input  5  aux destination register.
REQ-009 Aux_Data  input  32  aux write data.
REQ-010 Aux_ready  output  1  aux FIFO can accept; SHALL equal (count<2) and not reset.
REQ-011 Stall  output  1  registered; freezes the pipeline WB/MEM stages for one cycle.
REQ-012 RegWrite  output  1  registered register-file write enable.
REQ-013 RegWriteDst  output  5  registered register-file write address.
REQ-014 RegWriteData  output  32  registered register-file write data.
REQ-015 Grant_src  output  1  registered; 0 = pipeline, 1 = aux; source of the current write.

Function
REQ-016 Aux transfer SHALL occur when Aux_valid && Aux_ready at a rising edge; entry pushed into a 2-entry in-order FIFO.
REQ-017 Accepted aux transfers with Aux_Dst==0 SHALL be consumed but not stored (no FIFO slot, no write).
REQ-018 Aux_ready SHALL depend only on registered count; full FIFO SHALL not accept even if popped that cycle.
REQ-019 Pipeline request is eligible when Stall==0 && RegWrite_in==1 && RegWriteDst_in!=0; RegWrite_in while Stall==1 SHALL be ignored (pipeline re-presents it).
REQ-020 Priority per cycle: eligible pipeline request first; else FIFO head if non-empty (pop); else no write.
REQ-021 When Stall==1 and FIFO non-empty, FIFO head SHALL be granted and popped.
REQ-022 Grant in cycle N SHALL appear on RegWrite/RegWriteDst/RegWriteData/Grant_src in cycle N+1 (latency 1); no grant -> RegWrite=0, Dst/Data/Grant_src hold previous values.
REQ-023 Push and pop in the same cycle SHALL keep count unchanged and preserve order; pop of an entry pushed the same edge SHALL not occur (push visible next cycle).
REQ-024 Wait counter (4 bits): cleared on any pop or when FIFO empty; else increments each cycle FIFO non-empty and head not granted, saturating at STARVE_LIMIT.
REQ-025 When wait counter equals STARVE_LIMIT and Stall==0, Stall SHALL be 1 next cycle; Stall SHALL never be 1 for two consecutive cycles.
REQ-026 Write-after-write ordering between aux and pipeline to the same register is the requesters' responsibility; the block SHALL not reorder within the aux FIFO.

Reset
REQ-027 While reset==1: RegWrite=0, RegWriteDst=0, RegWriteData=0, Grant_src=0, Stall=0, Aux_ready=0, FIFO empty, wait counter 0.
REQ-028 Reset asserted mid-operation SHALL discard FIFO contents immediately (asynchronous); Aux_ready SHALL be 1 the first cycle after deassertion.

Verification
REQ-029 Pipeline only: RegWrite_in=1, Dst=5, Data=0xDEADBEEF -> next cycle RegWrite=1, RegWriteDst=5, RegWriteData=0xDEADBEEF, Grant_src=0.
REQ-030 Collision: aux push (Dst=7, 0x11) then pipeline Dst=3 every cycle, STARVE_LIMIT=4 -> Stall=1 exactly one cycle after 4 wait cycles, then RegWrite Dst=7 Data=0x11 Grant_src=1, counter cleared.
REQ-031 Full FIFO: two aux pushes with pipeline busy -> Aux_ready=0; third Aux_valid held, accepted only the cycle after a pop; write order 1st, 2nd, 3rd.
REQ-032 $0 filtering: pipeline Dst=0 with aux head Dst=9 -> aux granted same cycle; aux Dst=0 accepted, Aux_ready stays 1, no RegWrite.
REQ-033 Reset mid-operation: FIFO holding 2 entries, reset pulse -> all outputs 0, after release no aux write emerges, Aux_ready=1.
REQ-034 Idle: no requests 10 cycles -> RegWrite=0, Stall=0 throughout, RegWriteDst/RegWriteData unchanged.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Bundle of register-file write-back request and grant signals shared
// between the pipeline WB stage, the aux (MDU / late-load) unit and the arbiter.
interface wb_port_arbiter_if;
  logic        RegWrite_in;
  logic [4:0]  RegWriteDst_in;
  logic [31:0] WB_Data_in;
  logic        Aux_valid;
  logic [4:0]  Aux_Dst;
  logic [31:0] Aux_Data;
  logic        Aux_ready;
  logic        Stall;
  logic        RegWrite;
  logic [4:0]  RegWriteDst;
  logic [31:0] RegWriteData;
  logic        Grant_src;

  modport slave (
    input  RegWrite_in, RegWriteDst_in, WB_Data_in,
    input  Aux_valid, Aux_Dst, Aux_Data,
    output Aux_ready, Stall, RegWrite, RegWriteDst, RegWriteData, Grant_src
  );

  modport master (
    output RegWrite_in, RegWriteDst_in, WB_Data_in,
    output Aux_valid, Aux_Dst, Aux_Data,
    input  Aux_ready, Stall, RegWrite, RegWriteDst, RegWriteData, Grant_src
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Single register-file write port shared by the pipeline WB stage and a 2-entry
// aux FIFO; the pipeline has priority and a starvation timer forces a one-cycle stall.
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  wb_port_arbiter_if.slave  bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [4:0]  fifo_dst_q  [2];
  logic [31:0] fifo_data_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  count_q, count_d;
  logic [3:0]  wait_q, wait_d;
  logic        stall_q, stall_d;
  logic        regwrite_q, regwrite_d;
  logic [4:0]  dst_q, dst_d;
  logic [31:0] data_q, data_d;
  logic        src_q, src_d;

  logic pipe_elig, push, pop;

  // Ready depends only on registered count, so a full FIFO never accepts even when popped.
  assign bus.Aux_ready = !reset && (count_q < 2'd2);

  always_comb begin
    pipe_elig = !stall_q && bus.RegWrite_in && (bus.RegWriteDst_in != 5'd0);
    push      = bus.Aux_valid && bus.Aux_ready && (bus.Aux_Dst != 5'd0);
    pop       = !pipe_elig && (count_q != 2'd0);

    count_d = count_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;

    wait_d = wait_q;
    if (pop || count_q == 2'd0) wait_d = 4'd0;
    else if (wait_q != LIMIT)   wait_d = wait_q + 4'd1;

    stall_d = (wait_q == LIMIT) && !stall_q;

    regwrite_d = pipe_elig || pop;
    dst_d      = dst_q;
    data_d     = data_q;
    src_d      = src_q;
    if (pipe_elig) begin
      dst_d  = bus.RegWriteDst_in;
      data_d = bus.WB_Data_in;
      src_d  = 1'b0;
    end else if (pop) begin
      dst_d  = fifo_dst_q[rd_ptr_q];
      data_d = fifo_data_q[rd_ptr_q];
      src_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_dst_q[0]  <= '0;
      fifo_dst_q[1]  <= '0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      count_q        <= '0;
      wait_q         <= '0;
      stall_q        <= 1'b0;
      regwrite_q     <= 1'b0;
      dst_q          <= '0;
      data_q         <= '0;
      src_q          <= 1'b0;
    end else begin
      if (push) begin
        fifo_dst_q[wr_ptr_q]  <= bus.Aux_Dst;
        fifo_data_q[wr_ptr_q] <= bus.Aux_Data;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q    <= count_d;
      wait_q     <= wait_d;
      stall_q    <= stall_d;
      regwrite_q <= regwrite_d;
      dst_q      <= dst_d;
      data_q     <= data_d;
      src_q      <= src_d;
    end
  end

  assign bus.Stall        = stall_q;
  assign bus.RegWrite     = regwrite_q;
  assign bus.RegWriteDst  = dst_q;
  assign bus.RegWriteData = data_q;
  assign bus.Grant_src    = src_q;

endmodule
